// File: rtl/rs_age.sv
// rs_age: age-ordered reservation station with single-wide issue.
// Entries wait for their two source operands. The CDB broadcast ports
// wake up matching operands. The oldest ready entry issues into a
// registered output stage, which iss_stall_i can hold.
// A branch resolution clears its mask bit in every held op on a correct
// prediction, and squashes the dependent ops on a recovery.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   dp_*_i                 dispatch request and payload
//   cdb_vld_i, cdb_tag_i   CDB_NUM tag broadcasts, port p at [p*PRF_IDX_W +: PRF_IDX_W]
//   br_*_i                 branch resolution (correct / recovery, one-hot tag)
//   iss_stall_i            downstream cannot take the output register
//   iss_*_o                registered issue payload
//   full_o, free_cnt_o     occupancy, registered

`ifndef FU_SEL_NONE
`define FU_SEL_NONE 0
`endif

module rs_age #(
   parameter int unsigned ENT_NUM   = 16,
   parameter int unsigned CDB_NUM   = 2,
   parameter int unsigned PRF_IDX_W = 6,
   parameter int unsigned ROB_IDX_W = 5,
   parameter int unsigned BR_MASK_W = 4,
   parameter int unsigned FU_SEL_W  = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           dp_vld_i,
   input  logic [PRF_IDX_W-1:0]           dp_opa_tag_i,
   input  logic [PRF_IDX_W-1:0]           dp_opb_tag_i,
   input  logic [PRF_IDX_W-1:0]           dp_dest_tag_i,
   input  logic                           dp_opa_rdy_i,
   input  logic                           dp_opb_rdy_i,
   input  logic [FU_SEL_W-1:0]            dp_fu_sel_i,
   input  logic [31:0]                    dp_IR_i,
   input  logic [ROB_IDX_W-1:0]           dp_rob_idx_i,
   input  logic [BR_MASK_W-1:0]           dp_br_mask_i,
   input  logic [CDB_NUM-1:0]             cdb_vld_i,
   input  logic [CDB_NUM*PRF_IDX_W-1:0]   cdb_tag_i,
   input  logic                           br_pred_correct_i,
   input  logic                           br_recovery_i,
   input  logic [BR_MASK_W-1:0]           br_tag_fix_i,
   input  logic                           iss_stall_i,
   output logic                           iss_vld_o,
   output logic [PRF_IDX_W-1:0]           iss_opa_tag_o,
   output logic [PRF_IDX_W-1:0]           iss_opb_tag_o,
   output logic [PRF_IDX_W-1:0]           iss_dest_tag_o,
   output logic [FU_SEL_W-1:0]            iss_fu_sel_o,
   output logic [31:0]                    iss_IR_o,
   output logic [ROB_IDX_W-1:0]           iss_rob_idx_o,
   output logic [BR_MASK_W-1:0]           iss_br_mask_o,
   output logic                           full_o,
   output logic [$clog2(ENT_NUM+1)-1:0]   free_cnt_o
);

   localparam int unsigned IDX_W = $clog2(ENT_NUM);
   localparam int unsigned CNT_W = $clog2(ENT_NUM+1);

   typedef struct packed {
      logic [PRF_IDX_W-1:0] opa_tag;
      logic [PRF_IDX_W-1:0] opb_tag;
      logic [PRF_IDX_W-1:0] dest_tag;
      logic                 opa_rdy;
      logic                 opb_rdy;
      logic [FU_SEL_W-1:0]  fu_sel;
      logic [31:0]          ir;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [BR_MASK_W-1:0] br_mask;
   } ent_t;

   logic [ENT_NUM-1:0] vld_q, vld_d, rdy, grant;
   ent_t               ent_q [ENT_NUM];
   // older_q[i][j] set means entry i was dispatched before entry j
   logic [ENT_NUM-1:0] older_q [ENT_NUM];

   logic [IDX_W-1:0]     free_idx, iss_idx;
   logic                 free_found, any_grant;
   logic                 dp_acc, iss_en, iss_fire;
   logic [BR_MASK_W-1:0] fix_clr;
   logic [CNT_W-1:0]     free_cnt_d;
   ent_t                 dp_ent;

   // True when any valid CDB port carries tag
   function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0]         tag,
                                    input logic [CDB_NUM-1:0]           vld,
                                    input logic [CDB_NUM*PRF_IDX_W-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < int'(CDB_NUM); p++)
         if (vld[p] && (tags[p*PRF_IDX_W +: PRF_IDX_W] == tag)) hit = 1'b1;
      return hit;
   endfunction

   // Control qualifiers: recovery blocks dispatch and issue and overrides a correct prediction
   always_comb begin
      dp_acc  = dp_vld_i & ~full_o & ~br_recovery_i;
      iss_en  = ~br_recovery_i & (~iss_vld_o | ~iss_stall_i);
      fix_clr = (br_pred_correct_i && !br_recovery_i) ? br_tag_fix_i : '0;
   end

   // Oldest-ready select: an entry is blocked by any older ready entry
   always_comb begin
      rdy       = '0;
      grant     = '0;
      iss_idx   = '0;
      for (int i = 0; i < int'(ENT_NUM); i++)
         rdy[i] = vld_q[i] & ent_q[i].opa_rdy & ent_q[i].opb_rdy;
      for (int i = 0; i < int'(ENT_NUM); i++) begin
         grant[i] = rdy[i];
         for (int j = 0; j < int'(ENT_NUM); j++)
            if ((j != i) && rdy[j] && older_q[j][i]) grant[i] = 1'b0;
      end
      for (int i = 0; i < int'(ENT_NUM); i++)
         if (grant[i]) iss_idx = IDX_W'(i);
      any_grant = |grant;
      iss_fire  = iss_en & any_grant;
   end

   // Lowest-index free slot and the dispatch payload with CDB bypass
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < int'(ENT_NUM); i++)
         if (!vld_q[i] && !free_found) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      dp_ent.opa_tag  = dp_opa_tag_i;
      dp_ent.opb_tag  = dp_opb_tag_i;
      dp_ent.dest_tag = dp_dest_tag_i;
      dp_ent.opa_rdy  = dp_opa_rdy_i | cdb_hit(dp_opa_tag_i, cdb_vld_i, cdb_tag_i);
      dp_ent.opb_rdy  = dp_opb_rdy_i | cdb_hit(dp_opb_tag_i, cdb_vld_i, cdb_tag_i);
      dp_ent.fu_sel   = dp_fu_sel_i;
      dp_ent.ir       = dp_IR_i;
      dp_ent.rob_idx  = dp_rob_idx_i;
      dp_ent.br_mask  = dp_br_mask_i & ~fix_clr;
   end

   // Next valid vector and the occupancy it implies
   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < int'(ENT_NUM); i++)
         if (br_recovery_i && |(ent_q[i].br_mask & br_tag_fix_i)) vld_d[i] = 1'b0;
      if (iss_fire) vld_d[iss_idx] = 1'b0;
      if (dp_acc)   vld_d[free_idx] = 1'b1;
      free_cnt_d = '0;
      for (int i = 0; i < int'(ENT_NUM); i++)
         if (!vld_d[i]) free_cnt_d = free_cnt_d + CNT_W'(1);
   end

   // Entry array, age matrix and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= '0;
         full_o     <= 1'b0;
         free_cnt_o <= CNT_W'(ENT_NUM);
         for (int i = 0; i < int'(ENT_NUM); i++) begin
            ent_q[i]   <= '0;
            older_q[i] <= '0;
         end
      end else begin
         vld_q      <= vld_d;
         full_o     <= &vld_d;
         free_cnt_o <= free_cnt_d;
         for (int i = 0; i < int'(ENT_NUM); i++) begin
            ent_q[i].opa_rdy <= ent_q[i].opa_rdy | cdb_hit(ent_q[i].opa_tag, cdb_vld_i, cdb_tag_i);
            ent_q[i].opb_rdy <= ent_q[i].opb_rdy | cdb_hit(ent_q[i].opb_tag, cdb_vld_i, cdb_tag_i);
            ent_q[i].br_mask <= ent_q[i].br_mask & ~fix_clr;
         end
         if (dp_acc) begin
            ent_q[free_idx] <= dp_ent;
            // The new entry is younger than every other slot
            for (int i = 0; i < int'(ENT_NUM); i++)
               if (IDX_W'(i) != free_idx) older_q[i][free_idx] <= 1'b1;
            older_q[free_idx] <= '0;
         end
      end
   end

   // Issue output register
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_vld_o      <= 1'b0;
         iss_opa_tag_o  <= '0;
         iss_opb_tag_o  <= '0;
         iss_dest_tag_o <= '0;
         iss_fu_sel_o   <= FU_SEL_W'(`FU_SEL_NONE);
         iss_IR_o       <= '0;
         iss_rob_idx_o  <= '0;
         iss_br_mask_o  <= '0;
      end else begin
         iss_br_mask_o <= iss_br_mask_o & ~fix_clr;
         if (br_recovery_i) begin
            if (|(iss_br_mask_o & br_tag_fix_i)) iss_vld_o <= 1'b0;
         end else if (iss_en) begin
            iss_vld_o <= any_grant;
            if (any_grant) begin
               iss_opa_tag_o  <= ent_q[iss_idx].opa_tag;
               iss_opb_tag_o  <= ent_q[iss_idx].opb_tag;
               iss_dest_tag_o <= ent_q[iss_idx].dest_tag;
               iss_fu_sel_o   <= ent_q[iss_idx].fu_sel;
               iss_IR_o       <= ent_q[iss_idx].ir;
               iss_rob_idx_o  <= ent_q[iss_idx].rob_idx;
               iss_br_mask_o  <= ent_q[iss_idx].br_mask & ~fix_clr;
            end
         end
      end
   end

endmodule

// File: doc/rs_age.md
RS_AGE -- requirements
Module: rs_age

Interface
REQ-001 Parameter ENT_NUM, default 16, number of entries (power of two, >=4).
REQ-002 Parameter CDB_NUM, default 2, number of broadcast ports.
REQ-003 Parameters PRF_IDX_W, ROB_IDX_W, BR_MASK_W, FU_SEL_W, defaults 6, 5, 4, 3, field widths.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 dp_vld_i  in  1  dispatch request.
REQ-007 dp_opa_tag_i, dp_opb_tag_i, dp_dest_tag_i  in  PRF_IDX_W each  renamed tags.
REQ-008 dp_opa_rdy_i, dp_opb_rdy_i  in  1 each  operand already available.
REQ-009 dp_fu_sel_i  in  FU_SEL_W; dp_IR_i  in  32; dp_rob_idx_i  in  ROB_IDX_W; dp_br_mask_i  in  BR_MASK_W.
REQ-010 cdb_vld_i  in  CDB_NUM; cdb_tag_i  in  CDB_NUM*PRF_IDX_W, port p at bits [p*PRF_IDX_W +: PRF_IDX_W].
REQ-011 br_pred_correct_i  in  1; br_recovery_i  in  1; br_tag_fix_i  in  BR_MASK_W one-hot resolving branch.
REQ-012 iss_stall_i  in  1  downstream cannot accept the output register this cycle.
REQ-013 iss_vld_o  out  1; iss_opa_tag_o, iss_opb_tag_o, iss_dest_tag_o  out  PRF_IDX_W; iss_fu_sel_o  out  FU_SEL_W; iss_IR_o  out  32; iss_rob_idx_o  out  ROB_IDX_W; iss_br_mask_o  out  BR_MASK_W; all registered.
REQ-014 full_o  out  1; free_cnt_o  out  $clog2(ENT_NUM+1)  free entries, from registered state only.

Function
REQ-015 Dispatch accepted iff dp_vld_i & ~full_o & ~br_recovery_i; written into lowest-index free entry; dp_vld_i while full_o is dropped (upstream stalls on full_o).
REQ-016 Dispatch-cycle bypass: operand rdy bit stored set if dp_*_rdy_i or its tag equals any valid cdb_tag_i that cycle.
REQ-017 Wakeup: any valid entry operand whose tag matches any valid CDB port sets its rdy bit at the edge; multiple matching ports harmless.
REQ-018 Entry ready = valid & opa_rdy & opb_rdy (registered bits); entry written at edge t first selectable in cycle t+1.
REQ-019 Age matrix older[i][j]: on dispatch to k, row k cleared, column k set for all i != k; diagonal don't-care.
REQ-020 Issue select: ready entry i with no ready entry j where older[j][i]; exactly one grant; oldest-first, not index-priority.
REQ-021 Issue enable = ~br_recovery_i & (~iss_vld_o | ~iss_stall_i); when enabled and a grant exists, entry fields load the output register and entry freed at same edge.
REQ-022 Enabled with no grant: iss_vld_o <= 0 next cycle. Not enabled: output register holds (subject to REQ-023..025).
REQ-023 br_pred_correct_i (no recovery): clear br_tag_fix_i bits in every entry mask and in iss_br_mask_o; an entry dispatched same cycle stores dp_br_mask_i & ~br_tag_fix_i.
REQ-024 br_recovery_i: invalidate every entry with (mask & br_tag_fix_i) != 0; clear iss_vld_o if (iss_br_mask_o & br_tag_fix_i) != 0, else hold output; no dispatch, no issue.
REQ-025 br_pred_correct_i and br_recovery_i simultaneously: recovery wins, correct ignored.
REQ-026 Entry freed by issue or squash is dispatchable next cycle; free_cnt_o/full_o update at same edge.
REQ-027 Single-cycle pass-through latency: dispatch at edge t with both operands ready, empty RS, no stall -> iss_vld_o high after edge t+1.

Reset
REQ-028 rst: all entries invalid, age matrix zero, iss_vld_o=0, all iss_* data fields 0, iss_fu_sel_o=`FU_SEL_NONE, free_cnt_o=ENT_NUM, full_o=0.
REQ-029 rst dominates dispatch, CDB, branch and stall inputs in the same cycle.

Verification
REQ-030 Dispatch A (opa tag 5 not ready) then B (ready) then C (ready); CDB tag 5 -> B, C issue in order, then A; order B, C, A.
REQ-031 Fill 16 entries none ready -> full_o=1, free_cnt_o=0, 17th dp_vld_i dropped; CDB wakes entry 3 -> issues, free_cnt_o=1 next cycle.
REQ-032 Output valid, iss_stall_i=1 for 3 cycles with 2 ready entries -> output fields stable 3 cycles, no entry freed; stall drop -> next-oldest issues.
REQ-033 Entries masks 4'b0001, 4'b0010, output mask 4'b0001; br_recovery_i with tag_fix 4'b0001 -> entry 1 and iss_vld_o cleared, other entry kept, dispatch ignored that cycle.
REQ-034 br_pred_correct_i tag_fix 4'b0010 same cycle as dispatch mask 4'b0011 -> stored mask 4'b0001; existing 4'b0010 entries become 4'b0000.
REQ-035 Dispatch with opb tag equal to cdb_tag_i port 1 valid same cycle -> entry ready next cycle, iss_vld_o one cycle later.
